stopwatch_counter: RTL and testbench

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

---
 rtl/stopwatch_defs.sv | 17 +
 rtl/stopwatch_counter_bcd_digit.sv | 31 +++
 rtl/stopwatch_counter.sv | 119 +++++++++++
 tb/tb_stopwatch_counter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_defs.sv
// Shared definitions for the stopwatch: digit limits, default tick divider
// and the run-state codes.
package stopwatch_defs;

    localparam int TICK_DIV_DEFAULT = 1000000;

    localparam int SEC_ONES_MAX = 9;
    localparam int SEC_TENS_MAX = 5;
    localparam int MIN_ONES_MAX = 9;
    localparam int MIN_TENS_MAX = 5;

    typedef enum logic {
        STA_IDLE  = 1'b0,
        STA_COUNT = 1'b1
    } sta_t;

endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// One BCD digit of the stopwatch cascade. The digit counts 0..MAX and raises
// carry in the cycle it is told to increment while at MAX.
module bcd_digit #(
    parameter int MAX = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] q,
    output logic       carry
);

    localparam logic [3:0] MAX_Q = 4'(MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 4'd0;
        end else if (clr) begin
            q <= 4'd0;
        end else if (q > MAX_Q) begin
            // Out-of-range digit recovers to 0 regardless of inc.
            q <= 4'd0;
        end else if (inc) begin
            q <= (q == MAX_Q) ? 4'd0 : q + 4'd1;
        end
    end

    assign carry = inc & (q == MAX_Q);

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch: prescaler, four-digit BCD cascade, lap hold and
// registered run indicator.
//
//   state     | meaning
//   ----------+-------------------------------------------
//   STA_IDLE  | cnt_enable was low last edge (paused)
//   STA_COUNT | cnt_enable was high last edge (running)
module stopwatch_counter
    import stopwatch_defs::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cnt_enable,
    input  logic        clr,
    input  logic        lap,
    output logic [15:0] bcd_out,
    output logic        running,
    output logic        holding,
    output logic        wrap
);

    localparam int            PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    sta_t          state;
    sta_t          state_nxt;
    logic [PW-1:0] presc;
    logic          tick;
    logic [3:0]    q_so, q_st, q_mo, q_mt;
    logic          c_so, c_st, c_mo, c_mt;
    logic [15:0]   live;
    logic [15:0]   lap_reg;
    logic          hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STA_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = STA_IDLE;
        if (cnt_enable) begin
            state_nxt = STA_COUNT;
        end
    end

    assign running = (state == STA_COUNT);

    assign tick = cnt_enable & (presc == PRESC_LAST);

    // Prescaler freezes while paused so the fractional second survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (clr) begin
            presc <= '0;
        end else if (cnt_enable) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    bcd_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .clk(clk), .rst_n(rst_n), .inc(tick & ~clr), .clr(clr),
        .q(q_so), .carry(c_so)
    );

    bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .rst_n(rst_n), .inc(c_so), .clr(clr),
        .q(q_st), .carry(c_st)
    );

    bcd_digit #(.MAX(MIN_ONES_MAX)) u_min_ones (
        .clk(clk), .rst_n(rst_n), .inc(c_st), .clr(clr),
        .q(q_mo), .carry(c_mo)
    );

    bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .rst_n(rst_n), .inc(c_mo), .clr(clr),
        .q(q_mt), .carry(c_mt)
    );

    assign live = {q_mt, q_mo, q_st, q_so};

    // Carry out of the top digit marks the 59:59 -> 00:00 edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap <= 1'b0;
        end else if (clr) begin
            wrap <= 1'b0;
        end else begin
            wrap <= c_mt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold    <= 1'b0;
            lap_reg <= 16'h0000;
        end else if (clr) begin
            hold <= 1'b0;
        end else if (lap) begin
            if (!hold) begin
                hold    <= 1'b1;
                lap_reg <= live;
            end else begin
                hold <= 1'b0;
            end
        end
    end

    assign holding = hold;
    assign bcd_out = hold ? lap_reg : live;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed and randomized checks of stopwatch_counter (TICK_DIV=4) against
// a seconds-based reference model.
module tb_stopwatch_counter;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cnt_enable;
    logic        clr;
    logic        lap;
    logic [15:0] bcd_out;
    logic        running;
    logic        holding;
    logic        wrap;

    int n_pass = 0;
    int n_fail = 0;

    // Reference model: elapsed seconds, sub-second phase, lap snapshot.
    int m_secs, m_frac, m_lap;
    bit m_hold, m_run, m_wrap;

    stopwatch_counter #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .cnt_enable(cnt_enable), .clr(clr),
        .lap(lap), .bcd_out(bcd_out), .running(running),
        .holding(holding), .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_secs = 0; m_frac = 0; m_lap = 0;
        m_hold = 0; m_run = 0; m_wrap = 0;
    endtask

    task automatic model_edge(input bit en, input bit c, input bit l);
        bit tk;
        m_run = en;
        if (c) begin
            m_secs = 0; m_frac = 0; m_hold = 0; m_wrap = 0;
        end else begin
            tk = en && (m_frac == TD - 1);
            if (l) begin
                if (!m_hold) begin
                    m_hold = 1;
                    m_lap  = m_secs;
                end else begin
                    m_hold = 0;
                end
            end
            if (en) m_frac = (m_frac + 1) % TD;
            m_wrap = tk && (m_secs == 3599);
            if (tk) m_secs = (m_secs + 1) % 3600;
        end
    endtask

    task automatic chk_all();
        chk("bcd_out", 32'(bcd_out), 32'(to_bcd(m_hold ? m_lap : m_secs)));
        chk("running", 32'(running), 32'(m_run));
        chk("holding", 32'(holding), 32'(m_hold));
        chk("wrap",    32'(wrap),    32'(m_wrap));
    endtask

    task automatic cyc(input bit en, input bit c, input bit l);
        cnt_enable = en; clr = c; lap = l;
        @(posedge clk);
        model_edge(en, c, l);
        #1;
        chk_all();
    endtask

    task automatic run_until(input string tag, input int s, input int f);
        bit hit = 0;
        for (int i = 0; i < 20000; i++) begin
            if (m_secs == s && m_frac == f) begin
                hit = 1;
                break;
            end
            cyc(1, 0, 0);
        end
        chk({tag, "_reached"}, 32'(hit), 32'd1);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk_all();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    int wraps;
    bit seen_5959, seen_0000;

    initial begin
        rst_n = 1'b0; cnt_enable = 0; clr = 0; lap = 0;
        model_reset();
        #1;
        chk("rst_bcd", 32'(bcd_out), 32'h0);
        chk_all();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 40 running cycles -> 10 seconds.
        for (int i = 0; i < 40; i++) cyc(1, 0, 0);
        chk("run40_bcd", 32'(bcd_out), 32'h0010);

        // Pause at 00:03 with prescaler 2; fraction survives the pause.
        cyc(1, 1, 0);
        run_until("pause", 3, 2);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0);
        chk("pause_hold_bcd", 32'(bcd_out), 32'h0003);
        cyc(1, 0, 0);
        chk("resume1_bcd", 32'(bcd_out), 32'h0003);
        cyc(1, 0, 0);
        chk("resume2_bcd", 32'(bcd_out), 32'h0004);

        // Lap freeze and release.
        run_until("lap", 5, 0);
        cyc(1, 0, 1);
        for (int i = 0; i < 12; i++) cyc(1, 0, 0);
        chk("lap_frozen_bcd", 32'(bcd_out), 32'h0005);
        chk("lap_holding", 32'(holding), 32'd1);
        cyc(1, 0, 1);
        chk("lap_release_bcd", 32'(bcd_out), 32'h0008);

        // Lap while paused.
        cyc(0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0);
        cyc(0, 0, 1);

        // Randomized enable / lap / clear.
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
                $urandom_range(0, 15) == 0);

        // clr + lap on a tick edge at 00:12 while holding.
        cyc(1, 1, 0);
        cyc(1, 0, 1);
        run_until("clr_lap", 12, TD - 1);
        chk("clr_pre_holding", 32'(holding), 32'd1);
        cyc(1, 1, 1);
        chk("clr_bcd", 32'(bcd_out), 32'h0000);
        chk("clr_holding", 32'(holding), 32'd0);
        chk("clr_wrap", 32'(wrap), 32'd0);

        // Asynchronous reset mid-count at 01:34.
        run_until("areset", 94, 1);
        chk("areset_pre_bcd", 32'(bcd_out), 32'h0134);
        do_reset();
        for (int i = 0; i < TD - 1; i++) cyc(1, 0, 0);
        chk("post_rst_notick", 32'(bcd_out), 32'h0000);
        cyc(1, 0, 0);
        chk("post_rst_tick", 32'(bcd_out), 32'h0001);

        // Rollover 59:59 -> 00:00 with a single wrap pulse.
        run_until("wrap", 3598, 0);
        wraps = 0; seen_5959 = 0; seen_0000 = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 0);
            if (wrap) wraps++;
            if (bcd_out == 16'h5959) seen_5959 = 1;
            if (bcd_out == 16'h0000 && seen_5959) begin
                if (!seen_0000) chk("wrap_on_rollover", 32'(wrap), 32'd1);
                seen_0000 = 1;
            end
        end
        chk("wrap_count", 32'(wraps), 32'd1);
        chk("seen_5959", 32'(seen_5959), 32'd1);
        chk("seen_0000", 32'(seen_0000), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
